// File: rtl/cm_table_arbiter_pkg.sv
// Shared state encoding and packed-bus helpers for the CM table arbiter.
package cm_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_CM,
      WAIT_TRAIN,
      WAIT_FIN
   } arbState_t;

   // Bit offset of one lane's slice inside a packed per-lane context bus.
   function automatic int laneBase(input int lane, input int width);
      return lane * width;
   endfunction

   // Increment with wrap by comparison, so non-power-of-two lane counts work.
   function automatic int wrapInc(input int value, input int modulus);
      return (value >= modulus - 1) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/cm_table_arbiter_if.sv
// Lane-side and table-unit-side signal bundle of the CM table arbiter.
interface cm_table_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int CM_TW = 20,
   parameter int CM_DW = 32
);

   logic [N_REQ-1:0]          lu_req;
   logic [N_REQ*CM_TW-1:0]    lu_cxt;
   logic [N_REQ-1:0]          lu_gnt;
   logic [CM_DW-1:0]          cm_out;
   logic [N_REQ-1:0]          cm_valid;
   logic [N_REQ-1:0]          tr_valid;
   logic [N_REQ*CM_TW-1:0]    tr_cxt;
   logic [N_REQ-1:0]          tr_y;
   logic [N_REQ-1:0]          tr_ready;
   logic                      t_init_finish;
   logic [CM_TW-1:0]          t_lu_cxt;
   logic                      t_wr_b;
   logic [CM_DW-1:0]          t_cr_cm;
   logic                      t_crcm_valid;
   logic [CM_TW-1:0]          t_train_cxt;
   logic                      t_y;
   logic                      t_train_valid;
   logic                      t_train_ready;
   logic                      t_train_finish;
   logic                      busy;
   logic [$clog2(N_REQ)-1:0]  owner;
   logic                      err_spurious;

   // The arbiter itself sits on the slave side of the bundle.
   modport slave (
      input  lu_req, lu_cxt, tr_valid, tr_cxt, tr_y, t_init_finish,
             t_cr_cm, t_crcm_valid, t_train_ready, t_train_finish,
      output lu_gnt, cm_out, cm_valid, tr_ready, t_lu_cxt, t_wr_b,
             t_train_cxt, t_y, t_train_valid, busy, owner, err_spurious
   );

   modport master (
      output lu_req, lu_cxt, tr_valid, tr_cxt, tr_y, t_init_finish,
             t_cr_cm, t_crcm_valid, t_train_ready, t_train_finish,
      input  lu_gnt, cm_out, cm_valid, tr_ready, t_lu_cxt, t_wr_b,
             t_train_cxt, t_y, t_train_valid, busy, owner, err_spurious
   );

endinterface

// File: rtl/cm_table_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// ptr, wrapping past the top lane back to lane 0.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int IW = $clog2(N_REQ);

   // Scan upward from ptr; the wrap subtracts N_REQ instead of masking bits.
   always_comb begin
      int            cand;
      logic [IW-1:0] candIdx;
      idx     = '0;
      any     = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         candIdx = IW'(cand);
         if (!any && req[candIdx]) begin
            idx = candIdx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cm_table_arbiter.sv
// Round-robin arbiter locking the shared CM lookup/train unit to one lane
// from lookup issue until that lane's train write-back completes.
module cm_table_arbiter
   import cm_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int CM_TW = 20,
   parameter int CM_DW = 32
) (
   input logic               clk,
   input logic               rst,
   cm_table_arbiter_if.slave bus
);

   localparam int              OW    = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] LANE0 = N_REQ'(1);

   arbState_t        state;
   arbState_t        stateNext;
   logic [OW-1:0]    ownerQ;
   logic [OW-1:0]    rrPtr;
   logic [OW-1:0]    pickIdx;
   logic             pickAny;
   logic             grantNow;
   logic             ownerTrValid;
   logic             trainHandshake;
   logic             trainDone;
   logic             spuriousNow;
   logic [N_REQ-1:0] ownerMask;
   logic [N_REQ-1:0] luGntQ;
   logic [N_REQ-1:0] cmValidQ;
   logic [CM_DW-1:0] cmOutQ;
   logic [CM_TW-1:0] luCxtQ;
   logic             wrBQ;
   logic             errQ;

   rr_pick #(.N_REQ(N_REQ)) picker (
      .req (bus.lu_req),
      .ptr (rrPtr),
      .idx (pickIdx),
      .any (pickAny)
   );

   assign ownerMask      = LANE0 << ownerQ;
   assign ownerTrValid   = bus.tr_valid[ownerQ];
   assign grantNow       = (state == IDLE) && bus.t_init_finish && pickAny;
   assign trainHandshake = (state == WAIT_TRAIN) && ownerTrValid && bus.t_train_ready;
   assign trainDone      = (trainHandshake || (state == WAIT_FIN)) && bus.t_train_finish;

   // Unit responses outside their window, or a non-owner train attempt, are protocol slips.
   assign spuriousNow = (bus.t_crcm_valid && (state != WAIT_CM))
                     || (bus.t_train_finish && (state != WAIT_TRAIN) && (state != WAIT_FIN))
                     || ((state == WAIT_TRAIN) && |(bus.tr_valid & ~ownerMask));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // A finish arriving together with the train handshake skips WAIT_FIN.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:       if (grantNow) stateNext = ISSUE;
         ISSUE:      stateNext = WAIT_CM;
         WAIT_CM:    if (bus.t_crcm_valid) stateNext = WAIT_TRAIN;
         WAIT_TRAIN: if (trainHandshake) stateNext = bus.t_train_finish ? IDLE : WAIT_FIN;
         WAIT_FIN:   if (bus.t_train_finish) stateNext = IDLE;
         default:    stateNext = IDLE;
      endcase
   end

   // Registered pulses and captured values; grant, strobe and cm_valid each last one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         luGntQ   <= '0;
         wrBQ     <= 1'b0;
         cmValidQ <= '0;
         cmOutQ   <= '0;
         luCxtQ   <= '0;
         ownerQ   <= '0;
         rrPtr    <= '0;
         errQ     <= 1'b0;
      end else begin
         luGntQ   <= grantNow ? (LANE0 << pickIdx) : '0;
         wrBQ     <= (state == ISSUE);
         cmValidQ <= '0;
         if (grantNow) begin
            ownerQ <= pickIdx;
            luCxtQ <= bus.lu_cxt[laneBase(int'(pickIdx), CM_TW) +: CM_TW];
         end
         if ((state == WAIT_CM) && bus.t_crcm_valid) begin
            cmOutQ   <= bus.t_cr_cm;
            cmValidQ <= ownerMask;
         end
         if (trainDone) begin
            rrPtr <= OW'(wrapInc(int'(ownerQ), N_REQ));
         end
         if (spuriousNow) begin
            errQ <= 1'b1;
         end
      end
   end

   // Only the owner's train request reaches the unit, and only while WAIT_TRAIN.
   always_comb begin
      bus.t_train_valid = 1'b0;
      bus.t_train_cxt   = '0;
      bus.t_y           = 1'b0;
      bus.tr_ready      = '0;
      bus.busy          = (state != IDLE);
      if (state == WAIT_TRAIN) begin
         bus.t_train_valid = ownerTrValid;
         bus.t_train_cxt   = bus.tr_cxt[laneBase(int'(ownerQ), CM_TW) +: CM_TW];
         bus.t_y           = bus.tr_y[ownerQ];
         bus.tr_ready      = bus.t_train_ready ? ownerMask : '0;
      end
   end

   assign bus.lu_gnt       = luGntQ;
   assign bus.cm_out       = cmOutQ;
   assign bus.cm_valid     = cmValidQ;
   assign bus.t_lu_cxt     = luCxtQ;
   assign bus.t_wr_b       = wrBQ;
   assign bus.owner        = ownerQ;
   assign bus.err_spurious = errQ;

endmodule
